// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding,
// default operand width and the bit-counter width helper.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must hold bit indices 0..width-1; never narrower than one bit.
  function automatic int cntWidth(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with its own carry flop. The carry can be loaded
// synchronously (0 or 1) ahead of a serial operation and advances only
// when enabled. carryNext_o exposes the carry the next edge would store.
module serial_fa_cell (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic load_i,
  input  logic loadVal_i,
  input  logic a_i,
  input  logic b_i,
  output logic sumBit_o,
  output logic carryNext_o
);

  logic carry_q;
  logic carry_d;

  // Sum and majority carry of the current bit pair plus the stored carry.
  always_comb begin
    sumBit_o    = a_i ^ b_i ^ carry_q;
    carryNext_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);
  end

  // A load takes priority so a new operation always starts from a known carry-in.
  always_comb begin
    carry_d = carry_q;
    if (load_i) begin
      carry_d = loadVal_i;
    end else if (en_i) begin
      carry_d = carryNext_o;
    end
  end

  // Carry flop, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencing controller for a bit-serial adder. Operands are captured on
// start, streamed LSB-first through serial_fa_cell one bit per clock, and
// the serial sum is reassembled into a (WIDTH+1)-bit result with a done pulse.
// Optional subtraction is built in when SERIAL_ADD_CTRL_SUB_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] aShift_d;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] bShift_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH:0]   result_q;
  logic [WIDTH:0]   result_d;

  logic accept;
  logic shiftEn;
  logic lastBit;
  logic bOperand;
  logic carryLoadVal;
  logic sumBit;
  logic carryNext;

  assign accept  = (state_q == IDLE) && start;
  assign shiftEn = (state_q == SHIFT);
  assign lastBit = shiftEn && (cnt_q == LAST_BIT);

`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic subSel_q;
  logic subSel_d;

  // Subtract select is latched at acceptance so later changes on sub are harmless.
  always_comb begin
    subSel_d = subSel_q;
    if (accept) begin
      subSel_d = sub;
    end
  end

  // Subtract-select flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      subSel_q <= 1'b0;
    end else begin
      subSel_q <= subSel_d;
    end
  end

  // Two's-complement subtract: invert B and start with a carry of one.
  assign bOperand     = bShift_q[0] ^ subSel_q;
  assign carryLoadVal = sub;
`else
  assign bOperand     = bShift_q[0];
  assign carryLoadVal = 1'b0;
`endif

  serial_fa_cell u_fa (
    .clk         (clk),
    .reset       (reset),
    .en_i        (shiftEn),
    .load_i      (accept),
    .loadVal_i   (carryLoadVal),
    .a_i         (aShift_q[0]),
    .b_i         (bOperand),
    .sumBit_o    (sumBit),
    .carryNext_o (carryNext)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start only matters in IDLE; SHIFT runs until the last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = SHIFT;
      SHIFT:   if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand, counter and result next values; the result only moves during SHIFT.
  always_comb begin
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      aShift_d = a_in;
      bShift_d = b_in;
      cnt_d    = '0;
    end else if (shiftEn) begin
      aShift_d = aShift_q >> 1;
      bShift_d = bShift_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      result_d[WIDTH-1:0] = {sumBit, result_q[WIDTH-1:1]};
      if (lastBit) begin
        result_d[WIDTH] = carryNext;
      end
    end
  end

  // Datapath registers, all cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aShift_q <= '0;
      bShift_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign sum = result_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=5). Subtraction vectors
// are exercised when SERIAL_ADD_CTRL_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 5;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W:0]   expSum;
  } vecT;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic         subIn;
  logic         busy;
  logic         done;
  logic [W:0]   sum;

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a_in  (aIn),
    .b_in  (bIn),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub   (subIn),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One complete operation; inputs are scrambled after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               input logic [W:0] expSum, input string tag);
    int cycles;
    int busyCycles;
    bit seen;
    @(negedge clk);
    aIn = a; bIn = b; subIn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; aIn = a ^ 5'h15; bIn = ~b; subIn = ~s;
    cycles = 1; busyCycles = 0; seen = 1'b0;
    while (!seen && cycles <= 20) begin
      if (busy) busyCycles++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
    if (!seen) begin
      checkOutput({tag, "_timeout"}, 0, 1);
    end else begin
      checkOutput({tag, "_latency"}, cycles, W + 1);
      checkOutput({tag, "_sum"}, sum, expSum);
      checkOutput({tag, "_busyCycles"}, busyCycles, W + 1);
      @(negedge clk);
      checkOutput({tag, "_doneLow"}, done, 0);
      checkOutput({tag, "_busyLow"}, busy, 0);
      checkOutput({tag, "_sumHold"}, sum, expSum);
    end
  endtask

  vecT vecs[$];
  int doneCount;
  int doneAt[2];
  logic [W:0] doneSum[2];

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; aIn = '0; bIn = '0; subIn = 1'b0;

    vecs.push_back('{a: 5'd11, b: 5'd19, s: 1'b0, expSum: 6'd30});
    vecs.push_back('{a: 5'd31, b: 5'd31, s: 1'b0, expSum: 6'd62});
    vecs.push_back('{a: 5'd0,  b: 5'd0,  s: 1'b0, expSum: 6'd0});
    vecs.push_back('{a: 5'd1,  b: 5'd31, s: 1'b0, expSum: 6'd32});
    vecs.push_back('{a: 5'd8,  b: 5'd17, s: 1'b0, expSum: 6'd25});
    vecs.push_back('{a: 5'd22, b: 5'd6,  s: 1'b0, expSum: 6'd28});
    vecs.push_back('{a: 5'd16, b: 5'd16, s: 1'b0, expSum: 6'd32});
    vecs.push_back('{a: 5'd5,  b: 5'd0,  s: 1'b0, expSum: 6'd5});
`ifdef SERIAL_ADD_CTRL_SUB_EN
    vecs.push_back('{a: 5'd19, b: 5'd11, s: 1'b1, expSum: 6'b101000});
    vecs.push_back('{a: 5'd11, b: 5'd19, s: 1'b1, expSum: 6'b011000});
    vecs.push_back('{a: 5'd5,  b: 5'd5,  s: 1'b1, expSum: 6'd32});
    vecs.push_back('{a: 5'd10, b: 5'd3,  s: 1'b0, expSum: 6'd13});
`endif

    // Reset state, observed before any clock edge.
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum", sum, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].expSum, $sformatf("vec%0d", i));
    end

    // Back-to-back with start held high: second start accepted only once IDLE.
    @(negedge clk);
    aIn = 5'd0; bIn = 5'd0; subIn = 1'b0; start = 1'b1;
    @(negedge clk);
    aIn = 5'd1; bIn = 5'd31;
    doneCount = 0;
    for (int k = 1; k <= 30; k++) begin
      if (done) begin
        if (doneCount < 2) begin
          doneAt[doneCount] = k;
          doneSum[doneCount] = sum;
        end
        doneCount++;
        if (doneCount == 2) start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("b2b_doneCount", doneCount, 2);
    if (doneCount >= 2) begin
      checkOutput("b2b_firstAt", doneAt[0], 6);
      checkOutput("b2b_firstSum", doneSum[0], 0);
      checkOutput("b2b_secondAt", doneAt[1], 13);
      checkOutput("b2b_secondSum", doneSum[1], 32);
    end

    // Start pulsed mid-SHIFT must be ignored.
    @(negedge clk);
    aIn = 5'd8; bIn = 5'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aIn = 5'd7; bIn = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCount = 0;
    for (int k = 4; k <= 16; k++) begin
      if (done) begin
        if (doneCount == 0) begin
          doneAt[0] = k;
          doneSum[0] = sum;
        end
        doneCount++;
      end
      @(negedge clk);
    end
    checkOutput("midStart_doneCount", doneCount, 1);
    if (doneCount >= 1) begin
      checkOutput("midStart_doneAt", doneAt[0], 6);
      checkOutput("midStart_sum", doneSum[0], 25);
    end

    // Reset asserted just after E3 of 22+6 aborts the operation asynchronously.
    @(negedge clk);
    aIn = 5'd22; bIn = 5'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    checkOutput("abort_busyBefore", busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_sum", sum, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_staysIdleBusy", busy, 0);
    checkOutput("abort_staysIdleDone", done, 0);
    applyStimulus(5'd22, 5'd6, 1'b0, 6'd28, "afterAbort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencing controller for a bit-serial adder. It accepts two parallel WIDTH-bit operands on a start pulse and streams them LSB-first through a one-bit full-adder cell with a carry flop, one bit per clock. It reassembles the serial sum into a parallel (WIDTH+1)-bit result and signals completion with a one-cycle done pulse. It sits between a parallel requester and the serial-add datapath and owns all operand shifting, bit counting and carry state.

## Interface
- WIDTH, 5: operand width in bits, minimum 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; sampled with start.
- b_in  input  WIDTH  operand B; sampled with start.
- sub  input  1  subtract select; sampled with start. Present only with SERIAL_ADD_CTRL_SUB_EN.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH+1  result. sum[WIDTH] is the final carry.

## Operation
- Reset applies immediately, with no clock needed:
  - state=IDLE, busy=0, done=0, sum=0.
  - Operand shift registers, bit counter and carry flop are cleared.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE with start=1 at an edge:
  - Load a_in and b_in into shift registers.
  - Clear carry to 0; carry is 1 for subtract.
  - Clear the counter to 0 and go to SHIFT.
- SHIFT, at each edge:
  - Bit i = counter value. Sum bit = a[i]^b'[i]^carry; carry is updated to the majority of the three.
  - b' = b, or ~b when subtracting.
  - The sum bit shifts into the result register from the MSB side, so after WIDTH edges bit i sits at sum[i].
  - Operand registers shift right; the counter increments.
  - On the edge that processes bit WIDTH-1: sum[WIDTH] takes the final carry and state goes to DONE.
- DONE: done=1 for exactly one cycle, then the next edge returns to IDLE.
- Arithmetic:
  - Add: sum = a_in + b_in, exact (WIDTH+1 bits).
  - Subtract: sum[WIDTH-1:0] = (a_in - b_in) mod 2^WIDTH; sum[WIDTH]=1 means no borrow (a_in >= b_in).
- sum updates only in SHIFT and holds its value in DONE and IDLE until the next accepted start.
- start in SHIFT or DONE is ignored; it is neither queued nor able to corrupt the operation in progress.
- a_in, b_in and sub changes after the accepting edge have no effect.

## Timing
- Start accepted at edge E0.
- Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- done=1 and sum are valid in the cycle after E_WIDTH.
- The block is IDLE again after E_WIDTH+1.
- Latency from start to done is WIDTH+1 cycles; throughput is one operation per WIDTH+2 cycles.
- busy rises the cycle after E0 and falls together with done.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset asserted mid-operation aborts it. Outputs clear asynchronously, and after release a fresh start is required.

## Configuration
- SERIAL_ADD_CTRL_SUB_EN defined:
  - The sub port exists.
  - sub=1 at the accepting edge selects two's-complement subtraction (b inverted, carry-in 1).
- SERIAL_ADD_CTRL_SUB_EN undefined:
  - No sub port and no inversion logic.
  - Carry-in is always 0 and the block is add-only.

## Structure
- Shared package serial_add_pkg holds:
  - The state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - The default WIDTH constant.
  - The counter-width function (clog2 of WIDTH).
- One sub-module, serial_fa_cell: a one-bit full adder with its own carry flop, plus a synchronous carry-load input (value 0/1) and an enable.
- The controller instantiates one serial_fa_cell and contains the FSM, the operand and result shift registers, and the counter.

## Test plan
- WIDTH=5, start with a_in=11, b_in=19 -> done one cycle after E5, sum=6'b011110 (30), busy high for 6 cycles.
- a_in=31, b_in=31 -> sum=6'b111110 (62), carry propagates through every bit.
- a_in=0, b_in=0, then a_in=1, b_in=31 back-to-back, with start held high -> sums 0 then 32, the second start accepted only in IDLE.
- start pulsed again with a_in=7, b_in=7 mid-SHIFT while adding 8+17 -> sum=25, no second done pulse.
- Reset asserted at E3 of 22+6 -> outputs 0 immediately; a new start with 22+6 -> sum=28.
- SERIAL_ADD_CTRL_SUB_EN, sub=1: 19-11 -> sum=6'b101000; 11-19 -> sum=6'b011000 (borrow, low bits 24).
